// File: rtl/wb_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_reg_file_pkg
// Description : Shared CPU constants for write-back decode: opcode/funct
//               encodings, the link register index and the write class.
// Revision    : 1.0  initial release
// ============================================================================
package wb_reg_file_pkg;

   localparam logic [5:0] c_OP_SPECIAL = 6'h00;
   localparam logic [5:0] c_OP_JAL     = 6'h03;
   localparam logic [5:0] c_OP_ORI     = 6'h0d;
   localparam logic [5:0] c_OP_LUI     = 6'h0f;
   localparam logic [5:0] c_OP_LW      = 6'h23;

   localparam logic [5:0] c_FN_ADDU    = 6'h21;
   localparam logic [5:0] c_FN_SUBU    = 6'h23;

   localparam logic [4:0] RA           = 5'd31;

   typedef enum logic [2:0] {
      WC_NONE  = 3'd0,
      WC_RTYPE = 3'd1,
      WC_ITYPE = 3'd2,
      WC_LOAD  = 3'd3,
      WC_LINK  = 3'd4
   } wclass_e;

   // Map opcode/funct onto the register-write class; anything unknown writes nothing.
   function automatic wclass_e classify(input logic [5:0] op, input logic [5:0] fn);
      wclass_e c;
      c = WC_NONE;
      case (op)
         c_OP_SPECIAL: if (fn == c_FN_ADDU || fn == c_FN_SUBU) c = WC_RTYPE;
         c_OP_ORI,
         c_OP_LUI:     c = WC_ITYPE;
         c_OP_LW:      c = WC_LOAD;
         c_OP_JAL:     c = WC_LINK;
         default:      c = WC_NONE;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_reg_file_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_decode
// Description : Combinational write-back decode: picks destination register
//               and write data for the instruction in the WB stage and
//               suppresses writes to $0.
// Revision    : 1.0  initial release
// ============================================================================
module wb_decode
   import wb_reg_file_pkg::*;
(
   input  logic [31:0] i_ir,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_alu,
   output logic        o_we,
   output logic [4:0]  o_waddr,
   output logic [31:0] o_wdata
);

   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   wclass_e     w_class;
   logic [4:0]  w_dst;
   logic [31:0] w_data;
   logic        w_unused;

   assign w_opcode = i_ir[31:26];
   assign w_funct  = i_ir[5:0];
   assign w_rt     = i_ir[20:16];
   assign w_rd     = i_ir[15:11];
   // rs and shamt do not influence write-back.
   assign w_unused = ^{i_ir[25:21], i_ir[10:6]};

   // Select destination/data per class, then gate everything on a real, non-$0 write.
   always_comb begin
      w_class = classify(w_opcode, w_funct);
      w_dst   = 5'd0;
      w_data  = 32'd0;
      o_we    = 1'b0;
      o_waddr = 5'd0;
      o_wdata = 32'd0;
      case (w_class)
         WC_RTYPE: begin w_dst = w_rd; w_data = i_alu;         end
         WC_ITYPE: begin w_dst = w_rt; w_data = i_alu;         end
         WC_LOAD:  begin w_dst = w_rt; w_data = i_rdata;       end
         WC_LINK:  begin w_dst = RA;   w_data = i_pc + 32'd8;  end
         default:  begin w_dst = 5'd0; w_data = 32'd0;         end
      endcase
      if (w_class != WC_NONE && w_dst != 5'd0) begin
         o_we    = 1'b1;
         o_waddr = w_dst;
         o_wdata = w_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : wb_reg_file
// Description : 31-entry general register file written from the write-back
//               stage, with same-cycle write-to-read bypass and a retired
//               instruction counter.
// Revision    : 1.0  initial release
// ============================================================================
module wb_reg_file
   import wb_reg_file_pkg::*;
#(
   parameter logic [31:0] INIT_VALUE = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] WBIR,
   input  logic [31:0] WBRD,
   input  logic [31:0] WBPC,
   input  logic [31:0] WBALUOut,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic        grf_we,
   output logic [4:0]  grf_waddr,
   output logic [31:0] grf_wdata,
   output logic [31:0] retire_cnt
);

   logic        w_we;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;

   // $0 has no storage; entries 1..31 only.
   logic [31:0] r_regs [1:31];
   logic [31:0] r_retire_cnt;

   wb_decode u_decode (
      .i_ir    (WBIR),
      .i_rdata (WBRD),
      .i_pc    (WBPC),
      .i_alu   (WBALUOut),
      .o_we    (w_we),
      .o_waddr (w_waddr),
      .o_wdata (w_wdata)
   );

   assign grf_we     = w_we;
   assign grf_waddr  = w_waddr;
   assign grf_wdata  = w_wdata;
   assign retire_cnt = r_retire_cnt;

   // Register write port; reset clears asynchronously and wins over any pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= INIT_VALUE;
         end
      end else if (w_we) begin
         r_regs[w_waddr] <= w_wdata;
      end
   end

   // Count every non-bubble instruction leaving write-back; wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_retire_cnt <= INIT_VALUE;
      end else if (WBIR != 32'd0) begin
         r_retire_cnt <= r_retire_cnt + 32'd1;
      end
   end

   // Read port 1: $0 is hard zero, a same-cycle write is forwarded, else storage.
   always_comb begin
      RD1 = 32'd0;
      if (A1 == 5'd0)                     RD1 = 32'd0;
      else if (w_we && (A1 == w_waddr))   RD1 = w_wdata;
      else                                RD1 = r_regs[A1];
   end

   // Read port 2: identical policy to port 1.
   always_comb begin
      RD2 = 32'd0;
      if (A2 == 5'd0)                     RD2 = 32'd0;
      else if (w_we && (A2 == w_waddr))   RD2 = w_wdata;
      else                                RD2 = r_regs[A2];
   end

endmodule
`default_nettype wire
